// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch front end: PC, fetch tracking, stall/redirect
//
// Owns the program counter and drives the word-indexed instruction memory
// read address. The memory registers its output on the same edge that
// advances the PC, so this block registers the PC of that returned word
// (instr_pc) and whether it is an in-path, in-range instruction.
//
// Optional build macro: IF_FETCH_PERF_CNT_EN adds fetch/stall/squash counters.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   start         in   leave IDLE and begin fetching (sampled in IDLE only)
//   stall         in   hold PC and fetch outputs
//   redirect      in   taken branch/jump; wins over stall
//   redirect_pc   in   redirect target word address
//   Read_Address  out  current PC, to instruction memory
//   instr_pc      out  PC of the word on the memory output
//   instr_pc_next out  instr_pc + PC_STEP (raw add)
//   instr_valid   out  memory output is a valid in-path instruction
//   addr_err      out  sticky: a fetch was issued at PC >= IMEM_DEPTH
//   running       out  FSM is in RUN
//   fetch_cnt     out  (macro) edges that set instr_valid
//   stall_cnt     out  (macro) RUN cycles stalled without redirect
//   squash_cnt    out  (macro) redirects taken in RUN

module if_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int IMEM_DEPTH = 40,
  parameter int RESET_PC   = 0,
  parameter int PC_STEP    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] Read_Address,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_next,
  output logic              instr_valid,
  output logic              addr_err,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       squash_cnt,
`endif
  output logic              running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_in_range;
  logic              do_fetch;
  logic              do_redirect;
  logic              do_stall;

  assign pc_inc      = pc_q + STEP_W;
  assign pc_in_range = (pc_q < DEPTH_W);

  // Redirect beats stall; the IDLE->RUN edge is an unconditional fetch.
  assign do_redirect = (state_q == RUN) && redirect;
  assign do_stall    = (state_q == RUN) && !redirect && stall;
  assign do_fetch    = ((state_q == RUN) && !redirect && !stall) ||
                       ((state_q == IDLE) && start);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    addr_err_d    = addr_err_q;
    if (state_q == IDLE) begin
      instr_valid_d = 1'b0;
      if (start) state_d = RUN;
    end
    if (do_redirect) begin
      // Memory latches the wrong-path word at this edge; squash it.
      pc_d          = redirect_pc;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b0;
    end else if (do_fetch) begin
      instr_pc_d    = pc_q;
      instr_valid_d = pc_in_range;
      if (!pc_in_range) addr_err_d = 1'b1;
      pc_d          = (pc_inc >= DEPTH_W) ? '0 : pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RST_PC;
      instr_pc_q    <= RST_PC;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, squash_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (do_fetch && pc_in_range && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (do_stall && (stall_cnt_q != '1))                 stall_cnt_q <= stall_cnt_q + 32'd1;
      if (do_redirect && (squash_cnt_q != '1))             squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = do_stall;
`endif

  assign Read_Address  = pc_q;
  assign instr_pc      = instr_pc_q;
  assign instr_pc_next = instr_pc_q + STEP_W;
  assign instr_valid   = instr_valid_q;
  assign addr_err      = addr_err_q;
  assign running       = (state_q == RUN);

endmodule
